// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the mul/div issue arbiter: width defaults, op one-hot
// bit positions, FSM encodings and the wrap-aware ROB age comparison.
package exu_muldiv_pkg;

  localparam int ROB_ID_WIDTH_DEF   = 8;
  localparam int PRF_DATA_WIDTH_DEF = 32;
  localparam int PRF_CODE_WIDTH_DEF = 7;
  localparam int EXCP_WIDTH_DEF     = 5;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  localparam logic [7:0] DIV_CLASS_MASK = 8'((1 << OP_DIV) | (1 << OP_DIVU) | (1 << OP_REM) | (1 << OP_REMU));
  localparam logic [7:0] QUOT_MASK      = 8'((1 << OP_DIV) | (1 << OP_DIVU));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } mdu_state_e;

  // a is older than b; bit w-1 is the wrap bit, the bits below it are the index.
  function automatic logic older(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mask;
    logic [4:0]  msb;
    msb  = 5'(w - 1);
    mask = (32'd1 << msb) - 32'd1;
    if (a[msb] != b[msb]) return (a & mask) >= (b & mask);
    else                  return (a & mask) < (b & mask);
  endfunction

  function automatic logic is_div_class(input logic [7:0] op);
    return |(op & DIV_CLASS_MASK);
  endfunction

  function automatic logic is_quot(input logic [7:0] op);
    return |(op & QUOT_MASK);
  endfunction

endpackage

// File: rtl/exu_muldiv_arb_if.sv
// Bundle of the arbiter's flush, request, mul/div unit and writeback signals.
// master = environment side (drives requests/flushes), slave = arbiter side.
interface exu_muldiv_arb_if
  import exu_muldiv_pkg::*;
#(
  parameter int ROB_ID_WIDTH   = ROB_ID_WIDTH_DEF,
  parameter int PRF_DATA_WIDTH = PRF_DATA_WIDTH_DEF,
  parameter int PRF_CODE_WIDTH = PRF_CODE_WIDTH_DEF,
  parameter int EXCP_WIDTH     = EXCP_WIDTH_DEF
) ();
  // Handshakes: a request transfers when i_reqN_vld && o_reqN_rdy in the same
  // cycle; a writeback transfers when o_wb_vld && i_wb_rdy; o_wb_vld and its
  // payload stay stable until then (or until the entry is flushed).
  logic                      i_csr_trap_flush;
  logic                      i_exu_mis_flush;
  logic                      i_exu_ls_flush;
  logic [ROB_ID_WIDTH-1:0]   i_exu_mis_rob_id;
  logic [ROB_ID_WIDTH-1:0]   i_exu_ls_rob_id;
  logic                      i_req0_vld;
  logic                      o_req0_rdy;
  logic [ROB_ID_WIDTH-1:0]   i_req0_rob_id;
  logic [7:0]                i_req0_op;
  logic [PRF_DATA_WIDTH-1:0] i_req0_src1;
  logic [PRF_DATA_WIDTH-1:0] i_req0_src2;
  logic                      i_req0_dst_vld;
  logic [PRF_CODE_WIDTH-1:0] i_req0_dst_code;
  logic                      i_req1_vld;
  logic                      o_req1_rdy;
  logic [ROB_ID_WIDTH-1:0]   i_req1_rob_id;
  logic [7:0]                i_req1_op;
  logic [PRF_DATA_WIDTH-1:0] i_req1_src1;
  logic [PRF_DATA_WIDTH-1:0] i_req1_src2;
  logic                      i_req1_dst_vld;
  logic [PRF_CODE_WIDTH-1:0] i_req1_dst_code;
  logic                      o_mdu_vld;
  logic [7:0]                o_mdu_op;
  logic [PRF_DATA_WIDTH-1:0] o_mdu_src1;
  logic [PRF_DATA_WIDTH-1:0] o_mdu_src2;
  logic                      o_mdu_kill;
  logic                      i_mdu_done;
  logic [PRF_DATA_WIDTH-1:0] i_mdu_dat;
  logic                      o_wb_vld;
  logic                      i_wb_rdy;
  logic [ROB_ID_WIDTH-1:0]   o_wb_rob_id;
  logic                      o_wb_dst_vld;
  logic [PRF_CODE_WIDTH-1:0] o_wb_dst_code;
  logic [PRF_DATA_WIDTH-1:0] o_wb_dat;
  logic [EXCP_WIDTH-1:0]     o_wb_excp;
  mdu_state_e                o_dbg_state;

  modport master (
    output i_csr_trap_flush, i_exu_mis_flush, i_exu_ls_flush, i_exu_mis_rob_id, i_exu_ls_rob_id,
    output i_req0_vld, i_req0_rob_id, i_req0_op, i_req0_src1, i_req0_src2, i_req0_dst_vld, i_req0_dst_code,
    output i_req1_vld, i_req1_rob_id, i_req1_op, i_req1_src1, i_req1_src2, i_req1_dst_vld, i_req1_dst_code,
    output i_mdu_done, i_mdu_dat, i_wb_rdy,
    input  o_req0_rdy, o_req1_rdy, o_mdu_vld, o_mdu_op, o_mdu_src1, o_mdu_src2, o_mdu_kill,
    input  o_wb_vld, o_wb_rob_id, o_wb_dst_vld, o_wb_dst_code, o_wb_dat, o_wb_excp, o_dbg_state
  );

  modport slave (
    input  i_csr_trap_flush, i_exu_mis_flush, i_exu_ls_flush, i_exu_mis_rob_id, i_exu_ls_rob_id,
    input  i_req0_vld, i_req0_rob_id, i_req0_op, i_req0_src1, i_req0_src2, i_req0_dst_vld, i_req0_dst_code,
    input  i_req1_vld, i_req1_rob_id, i_req1_op, i_req1_src1, i_req1_src2, i_req1_dst_vld, i_req1_dst_code,
    input  i_mdu_done, i_mdu_dat, i_wb_rdy,
    output o_req0_rdy, o_req1_rdy, o_mdu_vld, o_mdu_op, o_mdu_src1, o_mdu_src2, o_mdu_kill,
    output o_wb_vld, o_wb_rob_id, o_wb_dst_vld, o_wb_dst_code, o_wb_dat, o_wb_excp, o_dbg_state
  );
endinterface

// File: rtl/exu_rob_age_cmp.sv
// Flush boundary selection and kill decision for one ROB id.
module exu_rob_age_cmp
  import exu_muldiv_pkg::*;
#(
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF
) (
  input  logic                    i_trap,
  input  logic                    i_mis_flush,
  input  logic                    i_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0] i_mis_rob_id,
  input  logic [ROB_ID_WIDTH-1:0] i_ls_rob_id,
  input  logic [ROB_ID_WIDTH-1:0] i_rob_id,
  output logic                    o_kill
);
  logic                    flush;
  logic [ROB_ID_WIDTH-1:0] boundary;

  always_comb begin
    flush = i_mis_flush | i_ls_flush;
    // With both flushes active the older boundary discards the wider range.
    if (i_mis_flush && i_ls_flush)
      boundary = older(32'(i_mis_rob_id), 32'(i_ls_rob_id), ROB_ID_WIDTH) ? i_mis_rob_id : i_ls_rob_id;
    else if (i_mis_flush)
      boundary = i_mis_rob_id;
    else
      boundary = i_ls_rob_id;
    o_kill = i_trap | (flush & older(32'(boundary), 32'(i_rob_id), ROB_ID_WIDTH));
  end
endmodule

// File: rtl/exu_muldiv_arb.sv
// Two-requester age-ordered arbiter in front of an iterative mul/div unit,
// holding one op from grant through writeback and honouring pipeline flushes.
module exu_muldiv_arb
  import exu_muldiv_pkg::*;
#(
  parameter int ROB_ID_WIDTH   = ROB_ID_WIDTH_DEF,
  parameter int PRF_DATA_WIDTH = PRF_DATA_WIDTH_DEF,
  parameter int PRF_CODE_WIDTH = PRF_CODE_WIDTH_DEF,
  parameter int EXCP_WIDTH     = EXCP_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_csr_trap_flush,
  input  logic                      i_exu_mis_flush,
  input  logic                      i_exu_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0]   i_exu_mis_rob_id,
  input  logic [ROB_ID_WIDTH-1:0]   i_exu_ls_rob_id,
  input  logic                      i_req0_vld,
  output logic                      o_req0_rdy,
  input  logic [ROB_ID_WIDTH-1:0]   i_req0_rob_id,
  input  logic [7:0]                i_req0_op,
  input  logic [PRF_DATA_WIDTH-1:0] i_req0_src1,
  input  logic [PRF_DATA_WIDTH-1:0] i_req0_src2,
  input  logic                      i_req0_dst_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_req0_dst_code,
  input  logic                      i_req1_vld,
  output logic                      o_req1_rdy,
  input  logic [ROB_ID_WIDTH-1:0]   i_req1_rob_id,
  input  logic [7:0]                i_req1_op,
  input  logic [PRF_DATA_WIDTH-1:0] i_req1_src1,
  input  logic [PRF_DATA_WIDTH-1:0] i_req1_src2,
  input  logic                      i_req1_dst_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_req1_dst_code,
  output logic                      o_mdu_vld,
  output logic [7:0]                o_mdu_op,
  output logic [PRF_DATA_WIDTH-1:0] o_mdu_src1,
  output logic [PRF_DATA_WIDTH-1:0] o_mdu_src2,
  output logic                      o_mdu_kill,
  input  logic                      i_mdu_done,
  input  logic [PRF_DATA_WIDTH-1:0] i_mdu_dat,
  output logic                      o_wb_vld,
  input  logic                      i_wb_rdy,
  output logic [ROB_ID_WIDTH-1:0]   o_wb_rob_id,
  output logic                      o_wb_dst_vld,
  output logic [PRF_CODE_WIDTH-1:0] o_wb_dst_code,
  output logic [PRF_DATA_WIDTH-1:0] o_wb_dat,
  output logic [EXCP_WIDTH-1:0]     o_wb_excp,
  output mdu_state_e                o_dbg_state
);
  mdu_state_e                state_q, state_d;
  logic [ROB_ID_WIDTH-1:0]   rob_id_q, rob_id_d;
  logic [7:0]                op_q, op_d;
  logic [PRF_DATA_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d, result_q, result_d;
  logic                      dst_vld_q, dst_vld_d;
  logic [PRF_CODE_WIDTH-1:0] dst_code_q, dst_code_d;

  logic                      kill0, kill1, kill_e;
  logic                      cand0, cand1, sel1, grant, win_zero;
  logic [7:0]                win_op;
  logic [PRF_DATA_WIDTH-1:0] win_src1, win_src2;
  logic                      ent_zero;
  logic [PRF_DATA_WIDTH-1:0] zero_res;

  exu_rob_age_cmp #(.ROB_ID_WIDTH(ROB_ID_WIDTH)) u_age_req0 (
    .i_trap(i_csr_trap_flush), .i_mis_flush(i_exu_mis_flush), .i_ls_flush(i_exu_ls_flush),
    .i_mis_rob_id(i_exu_mis_rob_id), .i_ls_rob_id(i_exu_ls_rob_id), .i_rob_id(i_req0_rob_id), .o_kill(kill0));
  exu_rob_age_cmp #(.ROB_ID_WIDTH(ROB_ID_WIDTH)) u_age_req1 (
    .i_trap(i_csr_trap_flush), .i_mis_flush(i_exu_mis_flush), .i_ls_flush(i_exu_ls_flush),
    .i_mis_rob_id(i_exu_mis_rob_id), .i_ls_rob_id(i_exu_ls_rob_id), .i_rob_id(i_req1_rob_id), .o_kill(kill1));
  exu_rob_age_cmp #(.ROB_ID_WIDTH(ROB_ID_WIDTH)) u_age_ent (
    .i_trap(i_csr_trap_flush), .i_mis_flush(i_exu_mis_flush), .i_ls_flush(i_exu_ls_flush),
    .i_mis_rob_id(i_exu_mis_rob_id), .i_ls_rob_id(i_exu_ls_rob_id), .i_rob_id(rob_id_q), .o_kill(kill_e));

  // Arbitration: only in IDLE, never during trap or reset; req0 wins ties.
  always_comb begin
    cand0    = (state_q == ST_IDLE) && !rst && !i_csr_trap_flush && i_req0_vld && !kill0;
    cand1    = (state_q == ST_IDLE) && !rst && !i_csr_trap_flush && i_req1_vld && !kill1;
    sel1     = cand1 && (!cand0 || older(32'(i_req1_rob_id), 32'(i_req0_rob_id), ROB_ID_WIDTH));
    grant    = cand0 || cand1;
    win_op   = sel1 ? i_req1_op   : i_req0_op;
    win_src1 = sel1 ? i_req1_src1 : i_req0_src1;
    win_src2 = sel1 ? i_req1_src2 : i_req0_src2;
    win_zero = is_div_class(win_op) && (win_src2 == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = win_zero ? ST_WB : ST_EXEC;
      ST_EXEC: begin
        if (kill_e)          state_d = ST_IDLE;
        else if (i_mdu_done) state_d = ST_WB;
      end
      ST_WB:   if (i_wb_rdy || kill_e) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divide-by-zero results are rebuilt from the latched operands at writeback.
  always_comb begin
    ent_zero      = is_div_class(op_q) && (src2_q == '0);
    zero_res      = is_quot(op_q) ? '1 : src1_q;
    o_req0_rdy    = grant && !sel1;
    o_req1_rdy    = sel1;
    o_mdu_vld     = grant && !win_zero;
    o_mdu_op      = o_mdu_vld ? win_op   : '0;
    o_mdu_src1    = o_mdu_vld ? win_src1 : '0;
    o_mdu_src2    = o_mdu_vld ? win_src2 : '0;
    o_mdu_kill    = (state_q == ST_EXEC) && kill_e && !rst;
    o_wb_vld      = (state_q == ST_WB);
    o_wb_rob_id   = o_wb_vld ? rob_id_q   : '0;
    o_wb_dst_vld  = o_wb_vld && dst_vld_q;
    o_wb_dst_code = o_wb_vld ? dst_code_q : '0;
    o_wb_dat      = '0;
    if (o_wb_vld) o_wb_dat = ent_zero ? zero_res : result_q;
    o_wb_excp     = '0;
    o_dbg_state   = state_q;
  end

  always_comb begin
    rob_id_d   = rob_id_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dst_vld_d  = dst_vld_q;
    dst_code_d = dst_code_q;
    result_d   = result_q;
    if (grant) begin
      rob_id_d   = sel1 ? i_req1_rob_id   : i_req0_rob_id;
      op_d       = win_op;
      src1_d     = win_src1;
      src2_d     = win_src2;
      dst_vld_d  = sel1 ? i_req1_dst_vld  : i_req0_dst_vld;
      dst_code_d = sel1 ? i_req1_dst_code : i_req0_dst_code;
      result_d   = '0;
    end else if ((state_q == ST_EXEC) && !kill_e && i_mdu_done) begin
      result_d = i_mdu_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_id_q   <= '0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_vld_q  <= 1'b0;
      dst_code_q <= '0;
      result_q   <= '0;
    end else begin
      rob_id_q   <= rob_id_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dst_vld_q  <= dst_vld_d;
      dst_code_q <= dst_code_d;
      result_q   <= result_d;
    end
  end
endmodule
